// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: video fetch, CPU req/ack and the VRAM port.
// slave = arbiter side, master = the surrounding blocks (video, CPU decode, VRAM).
interface vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_blank;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    // CPU handshake: cpu_req is held with stable we/addr/wdata until the
    // one-cycle cpu_ack pulse; dropping it before issue withdraws the access.
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_starve;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr, vid_blank, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_data, vid_valid, cpu_rdata, cpu_ack, cpu_starve, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr, vid_blank, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_data, vid_valid, cpu_rdata, cpu_ack, cpu_starve, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has absolute priority, CPU accesses fill
// free slots. Both requesters see a fixed 3-cycle issue-to-result latency.
module vram_arbiter #(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 8,
    parameter int CPU_BLANK_ONLY = 0,
    parameter int STARVE_LIMIT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    vram_arbiter_if.slave     bus,
    output logic              dbg_cpu_busy
);
    typedef enum logic {C_IDLE = 1'b0, C_BUSY = 1'b1} cpu_state_t;

    typedef struct packed {
        logic valid;
        logic src_cpu;
    } tag_t;

    localparam int              WAIT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
    localparam bit              BLANK_ONLY = (CPU_BLANK_ONLY != 0);

    cpu_state_t        state_q, state_d;
    tag_t              tag_q [3];
    tag_t              tag_d [3];
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_read_q, cpu_read_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starve_q, starve_d;

    logic              vid_issue;
    logic              cpu_issue;
    logic              cpu_done;

    always_comb begin
        vid_issue = bus.vid_req;
        cpu_issue = !bus.vid_req && (state_q == C_IDLE) && bus.cpu_req
                    && (!BLANK_ONLY || bus.vid_blank);
        // Tag in the last stage means this cycle carries the CPU ack.
        cpu_done  = tag_q[2].valid && tag_q[2].src_cpu;

        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (vid_issue) begin
            ram_addr_d = bus.vid_addr;
        end else if (cpu_issue) begin
            ram_addr_d  = bus.cpu_addr;
            ram_we_d    = bus.cpu_we;
            ram_wdata_d = bus.cpu_wdata;
        end

        tag_d[0].valid   = vid_issue || cpu_issue;
        tag_d[0].src_cpu = cpu_issue;
        tag_d[1]         = tag_q[0];
        tag_d[2]         = tag_q[1];

        // ram_rdata belongs to whichever slot sits in stage 1 right now.
        vid_data_d  = vid_data_q;
        cpu_rdata_d = cpu_rdata_q;
        if (tag_q[1].valid) begin
            if (!tag_q[1].src_cpu) begin
                vid_data_d = bus.ram_rdata;
            end else if (cpu_read_q) begin
                cpu_rdata_d = bus.ram_rdata;
            end
        end

        // Staying busy through the ack cycle blocks re-acceptance of a
        // request that is still high while ack is visible.
        state_d    = state_q;
        cpu_read_d = cpu_read_q;
        case (state_q)
            C_IDLE: begin
                if (cpu_issue) begin
                    state_d    = C_BUSY;
                    cpu_read_d = !bus.cpu_we;
                end
            end
            C_BUSY: begin
                if (cpu_done) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase

        wait_d = wait_q;
        if (cpu_issue) begin
            wait_d = '0;
        end else if ((state_q == C_IDLE) && bus.cpu_req && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end
        starve_d = starve_q || (wait_d == WAIT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= C_IDLE;
            for (int i = 0; i < 3; i++) begin
                tag_q[i] <= '0;
            end
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
            cpu_read_q  <= 1'b0;
            wait_q      <= '0;
            starve_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < 3; i++) begin
                tag_q[i] <= tag_d[i];
            end
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_read_q  <= cpu_read_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.vid_data   = vid_data_q;
    assign bus.vid_valid  = tag_q[2].valid && !tag_q[2].src_cpu;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ack    = cpu_done;
    assign bus.cpu_starve = starve_q;
    assign dbg_cpu_busy   = (state_q == C_BUSY);
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand sequences for starvation,
// blank-only gating and mid-access reset, then random traffic vs a slot model.
module tb_vram_arbiter;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int LIMIT = 64;
  localparam int NR    = 1500;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
  logic dbg_busy, dbg_busy_b;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_BLANK_ONLY(0), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .dbg_cpu_busy(dbg_busy)
  );
  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_BLANK_ONLY(1), .STARVE_LIMIT(LIMIT)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .dbg_cpu_busy(dbg_busy_b)
  );

  // VRAM model: synchronous read, one cycle after ram_addr.
  logic [DW-1:0] mem [2**AW];
  logic          mem_clr = 1'b0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_val = '0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_val;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end
  assign bus_b.ram_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.vid_req = 0; bus.vid_addr = '0; bus.vid_blank = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus_b.vid_req = 0; bus_b.vid_addr = '0; bus_b.vid_blank = 0;
    bus_b.cpu_req = 0; bus_b.cpu_we = 0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_addr = a; pre_val = v; pre_we = 1;
    ref_mem[a] = v;
    tick();
    pre_we = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 13'h1FFF;
    return AW'($urandom_range(0, 15));
  endfunction

  typedef struct {
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_val;
    logic          vid;
    logic [AW-1:0] vaddr;
    logic          cpu;
    logic          we;
    logic [AW-1:0] caddr;
    logic [DW-1:0] wdata;
    int            exp_vlat;
    logic [DW-1:0] exp_vdata;
    int            exp_alat;
    logic [DW-1:0] exp_rdata;
    int            exp_welat;
  } vec_t;
  vec_t vecs [7];

  bit            exp_vv  [NR+8];
  bit            exp_ack [NR+8];
  bit            exp_we  [NR+8];
  bit            exp_rdf [NR+8];
  logic [DW-1:0] exp_rdv [NR+8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vlat, alat, welat, ack_k, we_k, vcnt, ackcnt;
    int next_ok, waits, starve_at;
    logic [DW-1:0] m_rdata;

    vecs[0] = '{1, 13'h0030, 8'hA5, 1, 13'h0030, 0, 0, 13'h0000, 8'h00, 3, 8'hA5, 0, 8'h00, 0};
    vecs[1] = '{0, 13'h0000, 8'h00, 0, 13'h0000, 1, 1, 13'h1FFF, 8'h3C, 0, 8'hA5, 3, 8'h00, 1};
    vecs[2] = '{0, 13'h0000, 8'h00, 0, 13'h0000, 1, 0, 13'h1FFF, 8'h00, 0, 8'hA5, 3, 8'h3C, 0};
    vecs[3] = '{1, 13'h0100, 8'h77, 1, 13'h1FFF, 1, 0, 13'h0100, 8'h00, 3, 8'h3C, 4, 8'h77, 0};
    vecs[4] = '{0, 13'h0000, 8'h00, 0, 13'h0000, 1, 1, 13'h0000, 8'hFF, 0, 8'h3C, 3, 8'h77, 1};
    vecs[5] = '{0, 13'h0000, 8'h00, 1, 13'h0000, 0, 0, 13'h0000, 8'h00, 3, 8'hFF, 0, 8'h77, 0};
    vecs[6] = '{0, 13'h0000, 8'h00, 1, 13'h0030, 1, 1, 13'h0031, 8'h42, 3, 8'hA5, 4, 8'h77, 2};

    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    mem_clr = 1;
    do_reset();
    mem_clr = 0;

    // Reset state
    check("rst_vid_valid", bus.vid_valid, 0);
    check("rst_vid_data", bus.vid_data, 0);
    check("rst_cpu_ack", bus.cpu_ack, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_cpu_starve", bus.cpu_starve, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);
    check("rst_fsm_busy", dbg_busy, 0);

    // Directed single-transaction vectors
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pre_en) preload(vecs[v].pre_addr, vecs[v].pre_val);
      bus.vid_req = vecs[v].vid; bus.vid_addr = vecs[v].vaddr;
      bus.cpu_req = vecs[v].cpu; bus.cpu_we = vecs[v].we;
      bus.cpu_addr = vecs[v].caddr; bus.cpu_wdata = vecs[v].wdata;
      vlat = 0; alat = 0; welat = 0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (k == 1) bus.vid_req = 0;
        if (bus.vid_valid && vlat == 0) vlat = k;
        if (bus.cpu_ack && alat == 0) begin alat = k; bus.cpu_req = 0; end
        if (bus.ram_we && welat == 0) welat = k;
      end
      check($sformatf("vec%0d_vid_lat", v), vlat, vecs[v].exp_vlat);
      check($sformatf("vec%0d_vid_data", v), bus.vid_data, vecs[v].exp_vdata);
      check($sformatf("vec%0d_ack_lat", v), alat, vecs[v].exp_alat);
      check($sformatf("vec%0d_cpu_rdata", v), bus.cpu_rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d_we_lat", v), welat, vecs[v].exp_welat);
    end

    // Blank-only instance: write held with blank low for 10 cycles
    do_reset();
    bus_b.cpu_req = 1; bus_b.cpu_we = 1; bus_b.cpu_addr = 13'h0ABC; bus_b.cpu_wdata = 8'h5A;
    bus_b.vid_blank = 0;
    we_k = 0; ack_k = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus_b.ram_we) begin
        if (we_k == 0) we_k = k;
        check("blank_wdata", bus_b.ram_wdata, 8'h5A);
      end
      if (bus_b.cpu_ack && ack_k == 0) begin ack_k = k; bus_b.cpu_req = 0; end
      if (k == 10) bus_b.vid_blank = 1;
    end
    check("blank_we_cycle", we_k, 11);
    check("blank_ack_cycle", ack_k, 13);
    idle_inputs();

    // Starvation: video every cycle for 70 cycles with CPU read held
    do_reset();
    preload(13'h0055, 8'h9E);
    bus.vid_req = 1; bus.vid_addr = 13'h0010;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 13'h0055;
    ack_k = 0; vcnt = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (bus.vid_valid) vcnt++;
      if (k == 63) check("starve_before_limit", bus.cpu_starve, 0);
      if (k == 64) check("starve_at_limit", bus.cpu_starve, 1);
      if (bus.cpu_ack && ack_k == 0) begin
        ack_k = k;
        bus.cpu_req = 0;
        check("starve_rdata", bus.cpu_rdata, 8'h9E);
      end
      if (k == 70) bus.vid_req = 0;
    end
    check("starve_ack_cycle", ack_k, 73);
    check("starve_vid_count", vcnt, 70);
    check("starve_sticky", bus.cpu_starve, 1);

    // Reset in the middle of a CPU read
    do_reset();
    preload(13'h0200, 8'hC3);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 13'h0200;
    tick();
    check("midrst_ram_addr", bus.ram_addr, 13'h0200);
    check("midrst_busy_before", dbg_busy, 1);
    reset = 1; bus.cpu_req = 0;
    tick();
    reset = 0;
    check("midrst_ram_addr_clr", bus.ram_addr, 0);
    check("midrst_busy_after", dbg_busy, 0);
    check("midrst_cpu_ack", bus.cpu_ack, 0);
    ackcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.cpu_ack) ackcnt++;
    end
    check("midrst_no_ack", ackcnt, 0);
    bus.cpu_req = 1;
    alat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.cpu_ack && alat == 0) begin alat = k; bus.cpu_req = 0; end
    end
    check("midrst_new_ack_lat", alat, 3);
    check("midrst_new_rdata", bus.cpu_rdata, 8'hC3);

    // Random traffic against the slot model
    mem_clr = 1;
    do_reset();
    mem_clr = 0;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    for (int i = 0; i < NR + 8; i++) begin
      exp_vv[i] = 0; exp_ack[i] = 0; exp_we[i] = 0; exp_rdf[i] = 0; exp_rdv[i] = '0;
    end
    exp_q.delete();
    next_ok = 0; waits = 0; starve_at = -1; m_rdata = '0;
    for (int c = 0; c < NR; c++) begin
      if (exp_rdf[c]) m_rdata = exp_rdv[c];
      check("rnd_vid_valid", bus.vid_valid, exp_vv[c]);
      if (bus.vid_valid) begin
        if (exp_q.size() == 0) check("rnd_vid_unexpected", 1, 0);
        else check("rnd_vid_data", bus.vid_data, exp_q.pop_front());
      end
      check("rnd_cpu_ack", bus.cpu_ack, exp_ack[c]);
      check("rnd_ram_we", bus.ram_we, exp_we[c]);
      check("rnd_cpu_rdata", bus.cpu_rdata, m_rdata);
      check("rnd_cpu_starve", bus.cpu_starve, (starve_at >= 0 && c >= starve_at));

      if (bus.cpu_req && exp_ack[c]) begin
        bus.cpu_req = 0;
      end else if (bus.cpu_req && $urandom_range(0, 15) == 0) begin
        bus.cpu_req = 0;
      end else if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
        bus.cpu_req = 1;
        bus.cpu_we = $urandom_range(0, 1);
        bus.cpu_addr = rand_addr();
        bus.cpu_wdata = DW'($urandom_range(0, 255));
      end
      bus.vid_req = $urandom_range(0, 1);
      bus.vid_addr = rand_addr();
      bus.vid_blank = $urandom_range(0, 1);

      // Video always takes the slot; CPU gets it only when free and idle.
      if (bus.vid_req) begin
        exp_q.push_back(ref_mem[bus.vid_addr]);
        exp_vv[c+3] = 1;
      end
      if (!bus.vid_req && bus.cpu_req && c >= next_ok) begin
        exp_ack[c+3] = 1;
        next_ok = c + 4;
        waits = 0;
        if (bus.cpu_we) begin
          ref_mem[bus.cpu_addr] = bus.cpu_wdata;
          exp_we[c+1] = 1;
        end else begin
          exp_rdf[c+3] = 1;
          exp_rdv[c+3] = ref_mem[bus.cpu_addr];
        end
      end else if (bus.cpu_req && c >= next_ok) begin
        if (waits < LIMIT) waits++;
        if (waits == LIMIT && starve_at < 0) starve_at = c + 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
